// File: rtl/fp_to_twos_decoder.sv
// Serial decoder from an 8-bit float {S, E, F} to a W-bit two's-complement value.
// The significand is shifted left one bit per clock under a down-counter
// loaded with E. The sign is applied once the shift completes.
// Only FW + 2^EW - 1 <= W - 1 is supported: the magnitude then always fits in
// W-1 bits, so the sign bit of D is never lost.
module fp_to_twos_decoder #(
    parameter int W  = 12,
    parameter int EW = 3,
    parameter int FW = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic                S,
    input  logic [EW-1:0]       E,
    input  logic [FW-1:0]       F,
    output logic                out_valid,
    input  logic                out_ready,
    output logic signed [W-1:0] D
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [W-1:0]  mag;
    logic [EW-1:0] cnt;
    logic          sign_r;

    // Negate the unsigned magnitude when the sign bit is set.
    // A zero magnitude negates to zero, so negative zero cannot appear.
    function automatic logic signed [W-1:0] apply_sign(input logic s, input logic [W-1:0] m);
        logic [W-1:0] neg;
        neg = ~m + {{(W-1){1'b0}}, 1'b1};
        return s ? $signed(neg) : $signed(m);
    endfunction

    assign in_ready = (state == IDLE) && !rst;

    // State register; reset drops any operation in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic: accept in IDLE, count down in SHIFT, hold until consumed in DONE.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (in_valid)      state_nxt = SHIFT;
            SHIFT:   if (cnt == '0)     state_nxt = DONE;
            DONE:    if (out_ready)     state_nxt = IDLE;
            default:                    state_nxt = IDLE;
        endcase
    end

    // Datapath: capture inputs on accept, shift the magnitude, then publish D.
    always_ff @(posedge clk) begin
        if (rst) begin
            mag       <= '0;
            cnt       <= '0;
            sign_r    <= 1'b0;
            D         <= '0;
            out_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        mag    <= {{(W-FW){1'b0}}, F};
                        cnt    <= E;
                        sign_r <= S;
                    end
                end
                SHIFT: begin
                    if (cnt != '0) begin
                        mag <= mag << 1;
                        cnt <= cnt - {{(EW-1){1'b0}}, 1'b1};
                    end else begin
                        D         <= apply_sign(sign_r, mag);
                        out_valid <= 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                    end
                end
                default: begin
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule
